// File: rtl/cpu_bus_timer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_bus_timer
// Purpose  : Bus timing stage for the 65816 core. Stretches each CPU bus
//            cycle to FAST_LEN / SLOW_LEN / XSLOW_LEN master clocks according
//            to address region and FastROM select, generates the cpu_en and
//            cpu_en_m1 clock-enable pulses, drives read/write strobes,
//            latches read data, and inserts DRAM-refresh stalls and DMA halts
//            between CPU cycles.
// Ports    : clk          master clock
//            reset_n      synchronous active-low reset
//            addr[23:0]   CPU address, sampled at cycle start
//            bus_op[1:0]  0 internal, 1 read, 2 write, 3 treated as internal
//            memsel       FastROM enable
//            bus_rdata    external read data
//            refresh_req  one-clock refresh request pulse
//            dma_req      DMA bus request (level)
//            turbo        force fast cycles (only with CPU_BUS_TIMER_TURBO_EN)
//            cpu_en       pulse on the last master clock of a CPU cycle
//            cpu_en_m1    pulse one clock before cpu_en
//            mem_rdata    latched read data
//            rd_strobe    read strobe
//            wr_strobe    write strobe
//            dma_grant    CPU halted, bus owned by DMA
// Options  : CPU_BUS_TIMER_TURBO_EN adds the turbo input.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_bus_timer #(
  parameter int FAST_LEN    = 6,
  parameter int SLOW_LEN    = 8,
  parameter int XSLOW_LEN   = 12,
  parameter int REFRESH_LEN = 40,
  parameter int RESUME_LEN  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] addr,
  input  logic [1:0]  bus_op,
  input  logic        memsel,
  input  logic [7:0]  bus_rdata,
  input  logic        refresh_req,
  input  logic        dma_req,
`ifdef CPU_BUS_TIMER_TURBO_EN
  input  logic        turbo,
`endif
  output logic        cpu_en,
  output logic        cpu_en_m1,
  output logic [7:0]  mem_rdata,
  output logic        rd_strobe,
  output logic        wr_strobe,
  output logic        dma_grant
);

  localparam int CNT_W = 8;

  localparam logic [CNT_W-1:0] FAST_L  = CNT_W'(FAST_LEN);
  localparam logic [CNT_W-1:0] SLOW_L  = CNT_W'(SLOW_LEN);
  localparam logic [CNT_W-1:0] XSLOW_L = CNT_W'(XSLOW_LEN);
  localparam logic [CNT_W-1:0] REF_L   = CNT_W'(REFRESH_LEN);
  localparam logic [CNT_W-1:0] RES_L   = CNT_W'(RESUME_LEN);

  localparam logic [2:0] S_START   = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_REFRESH = 3'd2;
  localparam logic [2:0] S_HALT    = 3'd3;
  localparam logic [2:0] S_RESUME  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             is_rd_q, is_rd_d;
  logic             is_wr_q, is_wr_d;
  logic             strb_q, strb_d;       // low only on clock 2 of a cycle
  logic [7:0]       mem_rdata_q, mem_rdata_d;

  logic [CNT_W-1:0] w_cyc_len;
  logic             w_pend_now;
  logic [7:0]       w_bank;
  logic [15:0]      w_off;

  // --------------------------------------------------------------------------
  // Cycle length from the address region table
  // --------------------------------------------------------------------------
  always_comb begin
    w_bank    = addr[23:16];
    w_off     = addr[15:0];
    w_cyc_len = SLOW_L;
    if (bus_op == 2'd0 || bus_op == 2'd3) begin
      w_cyc_len = FAST_L;
    end else if (w_bank <= 8'h3F || (w_bank >= 8'h80 && w_bank <= 8'hBF)) begin
      if (w_off < 16'h2000)      w_cyc_len = SLOW_L;
      else if (w_off < 16'h4000) w_cyc_len = FAST_L;
      else if (w_off < 16'h4200) w_cyc_len = XSLOW_L;
      else if (w_off < 16'h6000) w_cyc_len = FAST_L;
      else if (w_off < 16'h8000) w_cyc_len = SLOW_L;
      else                       w_cyc_len = (w_bank >= 8'h80 && memsel) ? FAST_L : SLOW_L;
    end else if (w_bank <= 8'h7F) begin
      w_cyc_len = SLOW_L;
    end else begin
      w_cyc_len = memsel ? FAST_L : SLOW_L;
    end
`ifdef CPU_BUS_TIMER_TURBO_EN
    if (turbo) w_cyc_len = FAST_L;
`endif
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_START;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      is_rd_q     <= 1'b0;
      is_wr_q     <= 1'b0;
      strb_q      <= 1'b0;
      mem_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      is_rd_q     <= is_rd_d;
      is_wr_q     <= is_wr_d;
      strb_q      <= strb_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // A refresh pulse on the deciding clock itself counts as pending, and the
  // pulse that lands on the clock entering S_REFRESH is absorbed by that stall.
  assign w_pend_now = pend_q | refresh_req;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = w_pend_now;
    is_rd_d     = is_rd_q;
    is_wr_d     = is_wr_q;
    strb_d      = strb_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      S_START: begin
        cnt_d   = w_cyc_len - CNT_W'(2);
        is_rd_d = (bus_op == 2'd1);
        is_wr_d = (bus_op == 2'd2);
        strb_d  = 1'b0;
        state_d = S_RUN;
      end
      S_RUN: begin
        strb_d = 1'b1;
        if (cnt_q == CNT_W'(1) && is_rd_q) mem_rdata_d = bus_rdata;
        if (cnt_q == '0) begin
          if (w_pend_now) begin
            state_d = S_REFRESH;
            cnt_d   = REF_L - CNT_W'(1);
            pend_d  = 1'b0;
          end else if (dma_req) begin
            state_d = S_HALT;
          end else begin
            state_d = S_START;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_REFRESH: begin
        if (cnt_q == '0) state_d = dma_req ? S_HALT : S_START;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_HALT: begin
        if (!dma_req) begin
          state_d = S_RESUME;
          cnt_d   = RES_L - CNT_W'(1);
        end
      end
      S_RESUME: begin
        if (cnt_q == '0) begin
          if (w_pend_now) begin
            state_d = S_REFRESH;
            cnt_d   = REF_L - CNT_W'(1);
            pend_d  = 1'b0;
          end else begin
            state_d = S_START;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_START;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs (decoded from registered state only)
  // --------------------------------------------------------------------------
  always_comb begin
    cpu_en    = (state_q == S_RUN) && (cnt_q == '0);
    cpu_en_m1 = (state_q == S_RUN) && (cnt_q == CNT_W'(1));
    rd_strobe = (state_q == S_RUN) && is_rd_q && strb_q;
    wr_strobe = (state_q == S_RUN) && is_wr_q && strb_q;
    dma_grant = (state_q == S_HALT);
    mem_rdata = mem_rdata_q;
  end

endmodule
`default_nettype wire

// File: doc/cpu_bus_timer.md
Name: cpu_bus_timer

Overview:
- Upstream timing stage for the 65816 core: turns the CPU's per-cycle bus request into the `cpu_en` / `cpu_en_m1` clock-enable pulses consumed by the CPU controller and datapath.
- Stretches each CPU cycle to 6, 8 or 12 master clocks, depending on address region and the FastROM select.
- Drives read/write strobes and latches read data into `mem_rdata`.
- Inserts DRAM-refresh stalls and DMA halts between CPU cycles.

Parameters:
- `FAST_LEN`, 6, master clocks per fast cycle and per internal (idle) cycle.
- `SLOW_LEN`, 8, master clocks per slow cycle.
- `XSLOW_LEN`, 12, master clocks per extra-slow cycle.
- `REFRESH_LEN`, 40, master clocks per refresh stall.
- `RESUME_LEN`, 8, master clocks of resync after a DMA halt ends.

Ports:
- `clk`  in  1  master clock
- `reset_n`  in  1  synchronous, active-low reset
- `addr`  in  24  CPU bus address, valid at cycle start
- `bus_op`  in  2  0 = internal, 1 = read, 2 = write, 3 = reserved (treated as internal)
- `memsel`  in  1  FastROM enable ($420D bit 0)
- `bus_rdata`  in  8  external bus read data
- `refresh_req`  in  1  one-clk pulse requesting a refresh stall
- `dma_req`  in  1  level; DMA wants the bus
- `cpu_en`  out  1  one-clk pulse on the last master clock of a CPU cycle
- `cpu_en_m1`  out  1  one-clk pulse one clock before `cpu_en`
- `mem_rdata`  out  8  latched read data
- `rd_strobe`  out  1  read strobe to the bus
- `wr_strobe`  out  1  write strobe to the bus
- `dma_grant`  out  1  CPU is halted and the bus belongs to DMA

Behaviour:
- Reset (`reset_n` low at a rising edge):
  - state = S_START, `cnt` = 0, pending refresh flag = 0.
  - Outputs: `cpu_en` = 0, `cpu_en_m1` = 0, `rd_strobe` = 0, `wr_strobe` = 0, `dma_grant` = 0, `mem_rdata` = 8'h00.
  - Reset asserted mid-cycle abandons that cycle; no `cpu_en` is issued for it.
- Cycle length L, computed in S_START:
  - `bus_op` 0 or 3: `FAST_LEN`.
  - Banks $00-$3F and $80-$BF, by offset:
    - $0000-$1FFF: `SLOW_LEN`.
    - $2000-$3FFF: `FAST_LEN`.
    - $4000-$41FF: `XSLOW_LEN`.
    - $4200-$5FFF: `FAST_LEN`.
    - $6000-$7FFF: `SLOW_LEN`.
    - $8000-$FFFF: `SLOW_LEN`, except `FAST_LEN` when bank ≥ $80 and `memsel` = 1.
  - Banks $40-$7F: `SLOW_LEN`.
  - Banks $C0-$FF: `FAST_LEN` if `memsel` = 1, else `SLOW_LEN`.
- States: S_START, S_RUN, S_REFRESH, S_HALT, S_RESUME.
- S_START (first master clock of a CPU cycle):
  - Samples `addr`, `bus_op` and `memsel`; loads `cnt` = L-2; goes to S_RUN.
  - `addr`, `bus_op` and `memsel` changes during the rest of the cycle are ignored.
- S_RUN:
  - `cnt` decrements once per clk.
  - `cpu_en_m1` = 1 when `cnt` == 1; `cpu_en` = 1 when `cnt` == 0.
  - Result: `cpu_en` fires on master clock L of the cycle, counting S_START as clock 1.
- Strobes:
  - `rd_strobe` = 1 for a read from master clock 3 through clock L inclusive.
  - `wr_strobe` = 1 for a write over the same window.
  - Both are 0 during internal cycles and in every non-RUN state.
- Read data: `mem_rdata` <= `bus_rdata` on the clk where `cpu_en_m1` = 1 during a read; otherwise it holds.
- After the clock with `cpu_en` = 1, the next state is chosen in priority order:
  1. Pending refresh → S_REFRESH.
  2. `dma_req` = 1 → S_HALT.
  3. Otherwise → S_START.
- Refresh requests:
  - A `refresh_req` pulse arriving in any state sets the pending flag.
  - The flag is cleared on entry to S_REFRESH.
  - Two pulses before service collapse into one stall.
- S_REFRESH: lasts `REFRESH_LEN` clocks, no `cpu_en`; then re-checks `dma_req` (→ S_HALT) or goes to S_START.
- S_HALT: `dma_grant` = 1; stays while `dma_req` = 1; when `dma_req` is seen low, goes to S_RESUME.
- S_RESUME:
  - Lasts `RESUME_LEN` clocks with `dma_grant` = 0.
  - Then a pending refresh → S_REFRESH, else → S_START.
  - `dma_req` re-asserted during S_RESUME is honoured only after the next CPU cycle.
- Guarantees:
  - `cpu_en` is never asserted twice without an S_START in between.
  - `cpu_en` and `dma_grant` are never both 1.

Optional Feature:
- Macro: `CPU_BUS_TIMER_TURBO_EN`.
- When defined:
  - Adds input `turbo` (1 bit).
  - When `turbo` = 1 at S_START, L = `FAST_LEN` for every access, including XSLOW regions.
  - Refresh and DMA behaviour are unchanged.
- When undefined: the port is absent and timing follows the region table only.

Test Plan:
- After reset release: `addr` = $00_2100, `bus_op` = 1 → `cpu_en_m1` at clk 5, `cpu_en` at clk 6; `rd_strobe` high clks 3-6; `mem_rdata` = `bus_rdata` value $5A held from clk 5.
- Write to $00_4016 → `cpu_en` at clk 12, `wr_strobe` clks 3-12. Read of $80_8000 with `memsel` = 0 → L = 8; with `memsel` = 1 → L = 6.
- `refresh_req` pulse at clk 3 of a 6-clk cycle → `cpu_en` at clk 6, no `cpu_en` for the next 40 clks, next S_START at clk 47, next `cpu_en` at clk 52 for a fast cycle.
- `dma_req` raised mid-cycle and held 20 clks past the end of the cycle → `dma_grant` high starting the clk after `cpu_en`; after `dma_req` falls, 8 RESUME clks, then a normal cycle; `cpu_en` never overlaps `dma_grant`.
- `refresh_req` and `dma_req` both pending at the end of a cycle → REFRESH (40 clks) first, then HALT.
- `reset_n` low at clk 4 of a 12-clk cycle → no `cpu_en` for that cycle, all outputs 0, new cycle starts from S_START after release.
